// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the fetch stage: widths, fetch FSM encoding,
// fetch-buffer entry layout and the PC increment helper.
package pipeline_pkg;

  localparam int PC_W    = 11;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FULL   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input from
// the branch-target adder, and the IF/ID handshake. The fetch unit is the
// master; memory, adder and IF/ID register together form the slave side.
interface pc_fetch_unit_if;
  import pipeline_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               redirect_en;
  logic [PC_W-1:0]    redirect_pc;

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  redirect_en,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output redirect_en,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );

endinterface

// File: rtl/pc_fetch_unit_fetch_buf.sv
// Two-entry FIFO of {pc, instr} between instruction memory and IF/ID.
// Push and pop may happen together; flush empties it in one edge and wins
// over any push in the same cycle. Head outputs read as zero when empty.
module fetch_buf
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t entries [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // Storage, pointers and occupancy; flush resets occupancy but leaves data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entries[0] <= '0;
      entries[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  assign head       = head_valid ? entries[rd_ptr] : '0;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns the program counter, issues instruction-memory reads,
// buffers up to two fetched instructions toward IF/ID and squashes on
// redirect. Widths come from pipeline_pkg.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed
// counters; without it those ports and their logic do not exist.
module pc_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
)
(
  input  logic              clk,
  input  logic              reset_n,
  pc_fetch_unit_if.master   bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed
`endif
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_REQ    = REQ;
  localparam logic [1:0] ST_FULL   = FULL;
  localparam logic [1:0] ST_SQUASH = SQUASH;

  logic [1:0]      state;
  logic [1:0]      state_d;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] stale_addr;
  logic [PC_W-1:0] stale_addr_d;

  logic            pop;
  logic            push;
  logic            flush;
  logic            req_ack;
  logic            goes_full;
  logic [1:0]      count;
  logic            head_valid;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // A handshake at IF/ID always pops, even in a redirect cycle.
  assign pop       = head_valid && bus.if_ready;
  assign req_ack   = (state == ST_REQ) && bus.imem_ack;
  assign push      = req_ack && !bus.redirect_en;
  assign flush     = bus.redirect_en;
  // Only REQ pushes, and REQ never holds more than one entry, so the buffer
  // fills exactly when one entry is already there and nothing leaves.
  assign goes_full = (count == 2'd1) && !pop;

  assign push_entry.pc    = pc;
  assign push_entry.instr = bus.imem_rdata;

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  // Next state, next PC and the address a squashed request must keep driving.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    stale_addr_d = stale_addr;
    case (state)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (bus.redirect_en) begin
          pc_d = bus.redirect_pc;
        end
      end
      ST_REQ: begin
        if (bus.redirect_en) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_ack) begin
            state_d = ST_REQ;
          end else begin
            state_d      = ST_SQUASH;
            stale_addr_d = pc;
          end
        end else if (bus.imem_ack) begin
          pc_d    = pc_next(pc);
          state_d = goes_full ? ST_FULL : ST_REQ;
        end
      end
      ST_FULL: begin
        if (bus.redirect_en) begin
          pc_d    = bus.redirect_pc;
          state_d = ST_REQ;
        end else if (pop) begin
          state_d = ST_REQ;
        end
      end
      ST_SQUASH: begin
        if (bus.redirect_en) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.imem_ack) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, PC and stale-address registers; reset drops any open request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      stale_addr <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      stale_addr <= stale_addr_d;
    end
  end

  assign bus.imem_req  = (state == ST_REQ) || (state == ST_SQUASH);
  assign bus.imem_addr = (state == ST_SQUASH) ? stale_addr : pc;

  assign bus.if_valid  = head_valid;
  assign bus.if_instr  = head.instr;
  assign bus.if_pc     = head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic        discard;
  logic [31:0] squash_inc;

  // A response is thrown away when it lands in the redirect cycle or in SQUASH.
  assign discard = (req_ack && bus.redirect_en) ||
                   ((state == ST_SQUASH) && bus.imem_ack);

  // Entries lost to a flush, excluding the head if IF/ID took it that cycle.
  always_comb begin
    squash_inc = discard ? 32'd1 : 32'd0;
    if (bus.redirect_en) begin
      squash_inc = squash_inc + 32'(count) - (pop ? 32'd1 : 32'd0);
    end
  end

  // Free-running, wrapping event counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      perf_squashed <= perf_squashed + squash_inc;
    end
  end
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the 11-bit program counter and issues instruction-memory reads.
- Sources `old_pc` for the branch-target adder and sinks its `new_pc` as a redirect target.
- Buffers up to two fetched instructions toward the IF/ID register.
- Handles stall back-pressure and squash on redirect.

Parameters:
- PC_W, 11, PC/word-address width; wraps modulo 2^PC_W.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded by reset.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- imem_req  out  1  read request; once high, held with imem_addr stable until imem_ack.
- imem_addr  out  PC_W  word address of the current request.
- imem_ack  in  1  request complete; imem_rdata valid this cycle (zero-wait allowed).
- imem_rdata  in  INSTR_W  instruction data.
- redirect_en  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  PC_W  target, taken from the adder's new_pc.
- if_valid  out  1  head of fetch buffer valid.
- if_ready  in  1  IF/ID accepts; low = stall.
- if_instr  out  INSTR_W  head instruction.
- if_pc  out  PC_W  PC of the head instruction; feeds the adder's old_pc.

Behaviour:
- Reset (reset_n=0 at an edge): pc=RESET_PC, state=IDLE, buffer count=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0.
- Reset mid-request drops the request without waiting for ack.
- Fetch buffer: 2-entry FIFO of {pc, instr}; if_* show the head.
- Pop on if_valid&&if_ready. Push on imem_ack in REQ. Push and pop may occur in the same cycle.
- States:
  - IDLE: imem_req=0 → REQ next cycle. Only entered after reset.
  - REQ: imem_req=1, imem_addr=pc.
    - ack, no redirect: push {pc, rdata}, pc<=pc+1 (2047→0). → REQ if post-cycle count<=1, else FULL.
    - redirect, ack same cycle: data discarded, buffer flushed, pc<=redirect_pc → REQ.
    - redirect, no ack: buffer flushed, pc<=redirect_pc → SQUASH. imem_addr stays at the old address.
  - FULL: imem_req=0. → REQ when a pop occurs. Redirect: flush, pc<=redirect_pc → REQ.
  - SQUASH: imem_req=1 with the stale address. On ack, discard data → REQ.
    - Further redirect while in SQUASH: pc<=latest redirect_pc, stay SQUASH.
- Redirect priority: redirect > push > pop.
  - Flush clears count at the edge, so if_valid=0 the cycle after redirect_en.
  - A pop in the redirect cycle is still honoured: IF/ID takes the head.
- No overflow: a request is issued only when count<=1, and at most one response is outstanding.
- Latency: req→ack zero-wait gives 1 instr/cycle sustained. First if_valid appears 2 cycles after reset release.
- Arithmetic: pc+1 truncated to PC_W; redirect_pc used as-is.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_squashed[31:0], both reset to 0, wrapping.
  - perf_fetched increments on every push.
  - perf_squashed increments per flushed buffer entry, plus one per discarded ack.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package pipeline_pkg:
  - PC_W, INSTR_W.
  - fetch state enum {IDLE, REQ, FULL, SQUASH}.
  - typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_buf: 2-entry FIFO with push, pop, flush, count, and head outputs.
- FSM and PC register stay in pc_fetch_unit.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory, if_ready=1 → imem_addr 0,1,2,… each cycle; if_pc=0 at cycle 2 after release; one instr/cycle.
- Hold if_ready=0 for 5 cycles → exactly 2 entries fetched (pc 0,1), imem_req=0 in FULL; on release, pc 0,1 pop in order, then fetch resumes at 2.
- Ack delayed 3 cycles, redirect_en with redirect_pc=0x100 in wait cycle 1 → imem_addr held at old pc until ack; that data never appears on if_*; next request at 0x100.
- Redirect_en=1 with redirect_pc=0x040 in the same cycle as ack at pc=0x010 → data dropped, if_valid=0 next cycle, next if_pc=0x040.
- PC at 0x7FF, sequential fetch → next imem_addr=0x000.
- Assert reset_n=0 for one cycle while in SQUASH → all outputs at reset values next cycle; fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN defined, counters read 0.
